// File: rtl/regfile_wport_arbiter.sv
// regfile_wport_arbiter
// Shares the register-file write port between three writeback sources:
//   wb : pipeline writeback stage, never back-pressured, always wins the port
//   ld : load-return unit, valid/ready handshake
//   md : mul/div unit, valid/ready handshake
// ld and md contend round-robin when wb does not own the port. A request to
// register 0 is a null write: it is accepted immediately, uses no port slot
// and does not affect round-robin or starvation state.
// When ld/md sit blocked behind back-to-back wb writes for STARVE_LIMIT
// cycles, stall_req asks the pipeline to hold its writeback stage until the
// next ld/md grant.
//
// Ports:
//   clock          in   1   system clock, rising edge
//   reset          in   1   asynchronous, active-high reset
//   wb_valid       in   1   pipeline writeback request
//   wb_reg         in   5   pipeline destination register
//   wb_data        in  32   pipeline write data
//   ld_valid       in   1   load-return request
//   ld_ready       out  1   load request accepted this cycle (combinational)
//   ld_reg         in   5   load destination register
//   ld_data        in  32   load write data
//   md_valid       in   1   mul/div request
//   md_ready       out  1   mul/div request accepted this cycle (combinational)
//   md_reg         in   5   mul/div destination register
//   md_data        in  32   mul/div write data
//   stall_req      out  1   registered request to hold the writeback stage
//   rf_write_reg   out  5   register-file write register, 0 = no write
//   rf_write_data  out 32   register-file write data

module regfile_wport_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_reg,
  input  logic [31:0] ld_data,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_reg,
  input  logic [31:0] md_data,
  output logic        stall_req,
  output logic [4:0]  rf_write_reg,
  output logic [31:0] rf_write_data
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);

  // Port owner for the current cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_WB   = 2'd1,
    SRC_LD   = 2'd2,
    SRC_MD   = 2'd3
  } src_e;

  // Round-robin preference between the two handshaked sources.
  typedef enum logic {
    PTR_LD = 1'b0,
    PTR_MD = 1'b1
  } ptr_e;

  ptr_e              ptr_q,   ptr_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              stall_d;
  logic [REG_W-1:0]  wreg_d;
  logic [DATA_W-1:0] wdata_d;

  src_e owner;
  logic wb_live;
  logic ld_live;
  logic md_live;
  logic ldmd_grant;
  logic blocked;

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q         <= PTR_LD;
      cnt_q         <= '0;
      stall_req     <= 1'b0;
      rf_write_reg  <= '0;
      rf_write_data <= '0;
    end else begin
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      stall_req     <= stall_d;
      rf_write_reg  <= wreg_d;
      rf_write_data <= wdata_d;
    end
  end

  // Ownership, handshake, round-robin and starvation next-state.
  always_comb begin
    owner      = SRC_NONE;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    stall_d    = stall_req;
    wreg_d     = '0;
    wdata_d    = rf_write_data;
    ld_ready   = 1'b0;
    md_ready   = 1'b0;
    ldmd_grant = 1'b0;
    blocked    = 1'b0;

    // Null writes (register 0) never compete for the port.
    wb_live = wb_valid && (wb_reg != '0);
    ld_live = ld_valid && (ld_reg != '0);
    md_live = md_valid && (md_reg != '0);

    if (wb_live) begin
      owner = SRC_WB;
    end else if (ld_live && md_live) begin
      owner = (ptr_q == PTR_LD) ? SRC_LD : SRC_MD;
    end else if (ld_live) begin
      owner = SRC_LD;
    end else if (md_live) begin
      owner = SRC_MD;
    end

    // Nothing is accepted while reset is held; sources re-present afterwards.
    ld_ready = !reset && ld_valid && (!ld_live || (owner == SRC_LD));
    md_ready = !reset && md_valid && (!md_live || (owner == SRC_MD));

    blocked = (ld_live && (owner != SRC_LD)) || (md_live && (owner != SRC_MD));

    case (owner)
      SRC_WB: begin
        wreg_d  = wb_reg;
        wdata_d = wb_data;
      end
      SRC_LD: begin
        wreg_d     = ld_reg;
        wdata_d    = ld_data;
        ldmd_grant = 1'b1;
        ptr_d      = PTR_MD;
      end
      SRC_MD: begin
        wreg_d     = md_reg;
        wdata_d    = md_data;
        ldmd_grant = 1'b1;
        ptr_d      = PTR_LD;
      end
      default: begin
        wreg_d = '0;
      end
    endcase

    // Starvation only accrues while wb holds the port; any ld/md grant
    // resets it and releases the stall at the same edge.
    if (ldmd_grant) begin
      cnt_d   = '0;
      stall_d = 1'b0;
    end else if (blocked && (owner == SRC_WB)) begin
      if (cnt_q < CNT_LIMIT) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (cnt_d == CNT_LIMIT) begin
        stall_d = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Self-checking bench for regfile_wport_arbiter: directed scenarios with
// literal expectations, then randomized traffic checked every cycle against
// a behavioural model of the arbitration rules.

module tb_regfile_wport_arbiter;

  localparam int unsigned LIMIT = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_reg;
  logic [31:0] ld_data;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic        stall_req;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;

  regfile_wport_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_reg(ld_reg), .ld_data(ld_data),
    .md_valid(md_valid), .md_ready(md_ready), .md_reg(md_reg), .md_data(md_data),
    .stall_req(stall_req), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state.
  bit          m_prefer_ld;
  int          m_cnt;
  bit          m_stall;
  int          m_rf_reg;
  logic [31:0] m_rf_data;
  int          m_win;       // 0 none, 1 wb, 2 ld, 3 md
  bit          e_ld_ready;
  bit          e_md_ready;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endfunction

  task automatic model_reset();
    m_prefer_ld = 1'b1;
    m_cnt       = 0;
    m_stall     = 1'b0;
    m_rf_reg    = 0;
    m_rf_data   = '0;
  endtask

  // Who wins this cycle and which handshakes complete, from current inputs.
  task automatic model_eval();
    bit wl, ll, ml;
    wl = wb_valid && (wb_reg != 0);
    ll = ld_valid && (ld_reg != 0);
    ml = md_valid && (md_reg != 0);
    if (wl)            m_win = 1;
    else if (ll && ml) m_win = m_prefer_ld ? 2 : 3;
    else if (ll)       m_win = 2;
    else if (ml)       m_win = 3;
    else               m_win = 0;
    e_ld_ready = !reset && ld_valid && (ld_reg == 0 || m_win == 2);
    e_md_ready = !reset && md_valid && (md_reg == 0 || m_win == 3);
  endtask

  task automatic model_update();
    bit starving;
    if (reset) begin
      model_reset();
      return;
    end
    model_eval();
    starving = (ld_valid && ld_reg != 0 && m_win != 2) ||
               (md_valid && md_reg != 0 && m_win != 3);
    if (m_win == 2 || m_win == 3) begin
      m_cnt       = 0;
      m_stall     = 1'b0;
      m_prefer_ld = (m_win == 3);
    end else if (m_win == 1 && starving) begin
      if (m_cnt < LIMIT) m_cnt++;
      if (m_cnt == LIMIT) m_stall = 1'b1;
    end
    case (m_win)
      1: begin m_rf_reg = wb_reg; m_rf_data = wb_data; end
      2: begin m_rf_reg = ld_reg; m_rf_data = ld_data; end
      3: begin m_rf_reg = md_reg; m_rf_data = md_data; end
      default: m_rf_reg = 0;
    endcase
  endtask

  task automatic check_all();
    model_eval();
    chk("ld_ready",      32'(ld_ready),      32'(e_ld_ready));
    chk("md_ready",      32'(md_ready),      32'(e_md_ready));
    chk("stall_req",     32'(stall_req),     32'(m_stall));
    chk("rf_write_reg",  32'(rf_write_reg),  32'(m_rf_reg));
    chk("rf_write_data", rf_write_data,      m_rf_data);
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic tick();
    @(negedge clock);
    check_all();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid = 0; wb_reg = 0; wb_data = 0;
    ld_valid = 0; ld_reg = 0; ld_data = 0;
    md_valid = 0; md_reg = 0; md_data = 0;
  endtask

  int  wb_pct;
  bit  ld_acc, md_acc;

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_reset();
    #2;
    chk("reset rf_write_reg",  32'(rf_write_reg), 32'd0);
    chk("reset rf_write_data", rf_write_data,     32'd0);
    chk("reset stall_req",     32'(stall_req),    32'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Single pipeline write, then idle.
    wb_valid = 1; wb_reg = 5; wb_data = 32'hDEADBEEF;
    tick();
    wb_valid = 0;
    #1;
    chk("wb rf_write_reg",  32'(rf_write_reg), 32'd5);
    chk("wb rf_write_data", rf_write_data,     32'hDEADBEEF);
    tick();
    chk("wb idle rf_write_reg",  32'(rf_write_reg), 32'd0);
    chk("wb idle rf_write_data", rf_write_data,     32'hDEADBEEF);

    // ld and md together: ld preferred first, md next cycle.
    ld_valid = 1; ld_reg = 3; ld_data = 32'h11;
    md_valid = 1; md_reg = 4; md_data = 32'h22;
    #1;
    chk("rr c0 ld_ready", 32'(ld_ready), 32'd1);
    chk("rr c0 md_ready", 32'(md_ready), 32'd0);
    tick();
    ld_valid = 0;
    #1;
    chk("rr c1 rf_write_reg",  32'(rf_write_reg), 32'd3);
    chk("rr c1 rf_write_data", rf_write_data,     32'h11);
    chk("rr c1 md_ready",      32'(md_ready),     32'd1);
    tick();
    md_valid = 0;
    #1;
    chk("rr c2 rf_write_reg",  32'(rf_write_reg), 32'd4);
    chk("rr c2 rf_write_data", rf_write_data,     32'h22);
    tick();

    // Starvation behind continuous wb writes.
    wb_valid = 1; wb_reg = 20; wb_data = 32'hCAFE;
    ld_valid = 1; ld_reg = 7;  ld_data = 32'h77;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("starve stall_req", 32'(stall_req), (i == 4) ? 32'd1 : 32'd0);
    end
    wb_valid = 0;
    #1;
    chk("starve ld_ready", 32'(ld_ready), 32'd1);
    tick();
    ld_valid = 0;
    #1;
    chk("starve rf_write_reg",  32'(rf_write_reg), 32'd7);
    chk("starve rf_write_data", rf_write_data,     32'h77);
    chk("starve release",       32'(stall_req),    32'd0);
    tick();

    // Null wb does not block a load.
    wb_valid = 1; wb_reg = 0; wb_data = 32'hAAAA;
    ld_valid = 1; ld_reg = 9; ld_data = 32'h5;
    #1;
    chk("null wb ld_ready", 32'(ld_ready), 32'd1);
    tick();
    wb_valid = 0; ld_valid = 0;
    #1;
    chk("null wb rf_write_reg",  32'(rf_write_reg), 32'd9);
    chk("null wb rf_write_data", rf_write_data,     32'h5);

    // Null md is accepted at once and writes nothing.
    md_valid = 1; md_reg = 0; md_data = 32'h99;
    #1;
    chk("null md md_ready", 32'(md_ready), 32'd1);
    tick();
    md_valid = 0;
    #1;
    chk("null md rf_write_reg", 32'(rf_write_reg), 32'd0);
    tick();

    // Reset while stalled with a write in flight.
    wb_valid = 1; wb_reg = 12; wb_data = 32'h1200;
    ld_valid = 1; ld_reg = 13; ld_data = 32'h1313;
    repeat (4) tick();
    chk("pre-reset stall_req",    32'(stall_req),    32'd1);
    chk("pre-reset rf_write_reg", 32'(rf_write_reg), 32'd12);
    reset = 1;
    #1;
    model_reset();
    chk("mid reset stall_req",     32'(stall_req),     32'd0);
    chk("mid reset rf_write_reg",  32'(rf_write_reg),  32'd0);
    chk("mid reset rf_write_data", rf_write_data,      32'd0);
    chk("mid reset ld_ready",      32'(ld_ready),      32'd0);
    tick();
    reset = 0; wb_valid = 0;
    #1;
    chk("post reset ld_ready", 32'(ld_ready), 32'd1);
    tick();
    ld_valid = 0;
    #1;
    chk("post reset rf_write_reg",  32'(rf_write_reg), 32'd13);
    chk("post reset rf_write_data", rf_write_data,     32'h1313);
    tick();

    // Randomized traffic against the model.
    wb_pct = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 60 == 0) wb_pct = ($urandom_range(0, 2) == 0) ? 95 : $urandom_range(10, 60);
      wb_valid = ($urandom_range(0, 99) < (m_stall ? 5 : wb_pct));
      wb_reg   = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      wb_data  = $urandom;
      if (!ld_valid && $urandom_range(0, 2) == 0) begin
        ld_valid = 1;
        ld_reg   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        ld_data  = $urandom;
      end
      if (!md_valid && $urandom_range(0, 3) == 0) begin
        md_valid = 1;
        md_reg   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        md_data  = $urandom;
      end
      if ($urandom_range(0, 399) == 0) begin
        reset = 1;
        #1;
        model_reset();
        check_all();
        tick();
        reset = 0;
        #1;
      end
      @(negedge clock);
      check_all();
      ld_acc = e_ld_ready;
      md_acc = e_md_ready;
      @(posedge clock);
      model_update();
      #1;
      if (ld_acc) ld_valid = 0;
      if (md_acc) md_valid = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_wport_arbiter.md
Name: regfile_wport_arbiter

Overview:
- Shares the single register-file write port between three writeback sources.
- Sources: pipeline writeback stage (wb, no backpressure), load-return unit (ld, valid/ready) and multi-cycle mul/div unit (md, valid/ready).
- Drives the register file's write-data/write-register inputs from a registered output stage.
- Requests a one-shot pipeline stall when ld/md are starved by back-to-back pipeline writes.

Parameters:
- STARVE_LIMIT, 4, consecutive blocked cycles (ld or md pending, not granted) before stall_req asserts; legal 1..15.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- wb_valid  in  1  pipeline writeback request; never back-pressured
- wb_reg  in  5  pipeline destination register
- wb_data  in  32  pipeline write data
- ld_valid  in  1  load-return request
- ld_ready  out  1  load request accepted this cycle (combinational)
- ld_reg  in  5  load destination register
- ld_data  in  32  load write data
- md_valid  in  1  mul/div request
- md_ready  out  1  mul/div request accepted this cycle (combinational)
- md_reg  in  5  mul/div destination register
- md_data  in  32  mul/div write data
- stall_req  out  1  registered; asks the pipeline to hold its writeback stage
- rf_write_reg  out  5  register-file write register; 0 means no write
- rf_write_data  out  32  register-file write data

Behaviour:
- Reset (async, immediate): rf_write_reg=0, rf_write_data=0, stall_req=0, starve counter=0, round-robin pointer=ld.
- A request to register 0 is a null write:
  - it is accepted (ready=1 for ld/md) and consumes no port slot;
  - it is not counted as a grant for round-robin or starvation purposes.
- Port owner each cycle (combinational):
  - A non-null wb always owns the port.
  - Otherwise ld/md contend round-robin: the pointer names the preferred source. If only one non-null source is valid, it wins.
  - After an ld or md grant, the pointer moves to the other source.
- ld_ready = ld_valid && (ld_reg==0 || ld granted); md_ready likewise. Ready never asserts without valid.
- Payload must be held stable while valid && !ready; valid must not drop until accepted. This is a bench assertion and is not checked in RTL.
- Output stage, 1-cycle latency:
  - At the posedge after a non-null grant: rf_write_reg/rf_write_data take the granted reg/data.
  - At a posedge with no non-null grant: rf_write_reg=0; rf_write_data holds its previous value.
  - The register file writes at the following posedge and bypasses same-cycle reads.
- Starvation counter (4 bits):
  - "blocked" = (ld_valid && ld_reg!=0 && !ld_ready) || (md_valid && md_reg!=0 && !md_ready).
  - Increments on each blocked cycle while wb holds the port; saturates at STARVE_LIMIT.
  - Clears on any ld/md non-null grant.
  - Holds on cycles that are neither blocked nor granting.
- stall_req:
  - Sets at the posedge where the counter reaches STARVE_LIMIT.
  - Clears at the posedge after the next ld/md non-null grant.
  - The pipeline should present wb_valid=0 while stall_req=1. If wb_valid=1 arrives anyway, wb still wins; no write is ever dropped and stall_req stays set.
- Simultaneous ld+md with non-null wb: both wait; counts as one blocked cycle.
- Simultaneous ld+md, no wb: the pointer's source wins; the other waits one cycle and is granted next (it is now preferred).
- Reset mid-transfer: pending ld/md requests are neither accepted nor lost by this block; the sources re-present after reset. An output write in flight is cancelled (rf_write_reg=0).

Test Plan:
- Reset, then wb_valid=1 wb_reg=5 wb_data=0xDEADBEEF for one cycle -> next cycle rf_write_reg=5 rf_write_data=0xDEADBEEF; cycle after, rf_write_reg=0.
- ld(reg 3, 0x11) and md(reg 4, 0x22) valid together, no wb -> ld_ready in cycle 0, rf 3/0x11 in cycle 1; md_ready in cycle 1, rf 4/0x22 in cycle 2; pointer back to ld.
- wb non-null every cycle, ld_valid reg 7, STARVE_LIMIT=4 -> stall_req=1 after 4th blocked edge. Drop wb_valid -> ld_ready same cycle, rf 7 next edge, stall_req=0 the edge after grant.
- wb_valid reg 0 plus ld_valid reg 9 data 0x5 -> ld granted same cycle, rf 9/0x5 next cycle; wb produces no write.
- md_valid reg 0 -> md_ready=1 immediately; rf_write_reg stays 0; counter and pointer unchanged.
- Assert reset while stall_req=1 and rf_write_reg=12 -> immediately stall_req=0, rf_write_reg=0, counter 0; after release, pending ld re-presented is granted normally.
